pipelined_cpu16: RTL and testbench

- 16-bit, 5-stage in-order pipelined RISC core (IF, ID, EX, MEM, WB).
- Eight 16-bit general registers gr[0..7] and flags cf/zf/nf.
- Separate instruction and data memory ports with 8-bit addresses.
- Top-level processor used by the system and by the CPU test benches. It has no hazard interlock; software inserts NOPs.

---
 rtl/cpu16_pkg.sv | 68 ++++++
 rtl/cpu16_alu.sv | 42 ++++
 rtl/pipelined_cpu16.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_cpu16.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared ISA definitions for the 16-bit pipelined core: opcodes, run state,
// flag bit positions and small opcode-class helpers used by decode and writeback.
package cpu16_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic [15:0] NOP_IR = 16'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int CF = 0;
    localparam int ZF = 1;
    localparam int NF = 2;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SLA) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_cond_branch(input logic [4:0] op);
        return (op >= OP_BZ);
    endfunction

    // Add/sub family: these are the only ops that produce a new carry.
    function automatic logic is_arith(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_SUBI) ||
               (op == OP_CMP) || (op == OP_ADDC) || (op == OP_SUBC);
    endfunction

    function automatic logic sets_flags(input logic [4:0] op);
        return is_arith(op) || is_shift(op) ||
               (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_LDIH) ||
               (sets_flags(op) && (op != OP_CMP));
    endfunction

endpackage

// File: rtl/cpu16_alu.sv
// Combinational ALU for the EX stage: computes the result and the candidate
// cf/zf/nf; the caller decides whether the flags are actually committed.
module cpu16_alu
    import cpu16_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cf_in,
    output logic [15:0] result,
    output logic        cf_out,
    output logic        zf_out,
    output logic        nf_out
);

    logic [16:0] wide;
    logic [15:0] sra_val;

    always_comb begin
        sra_val = 16'($signed(a) >>> b[3:0]);
        wide    = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADDC:                  wide = {1'b0, a} + {1'b0, b} + {16'b0, cf_in};
            OP_SUB, OP_SUBI, OP_CMP:  wide = {1'b0, a} - {1'b0, b};
            OP_SUBC:                  wide = {1'b0, a} - {1'b0, b} - {16'b0, cf_in};
            OP_AND:                   wide = {1'b0, a & b};
            OP_OR:                    wide = {1'b0, a | b};
            OP_XOR:                   wide = {1'b0, a ^ b};
            OP_SLL, OP_SLA:           wide = {1'b0, a << b[3:0]};
            OP_SRL:                   wide = {1'b0, a >> b[3:0]};
            OP_SRA:                   wide = {1'b0, sra_val};
            default:                  wide = {1'b0, a} + {1'b0, b};
        endcase
    end

    assign result = wide[15:0];
    // Bit 16 is carry for adds and borrow for subtracts.
    assign cf_out = is_arith(op) ? wide[16] : cf_in;
    assign zf_out = (wide[15:0] == 16'h0000);
    assign nf_out = wide[15];

endmodule

// File: rtl/pipelined_cpu16.sv
// 16-bit five-stage (IF/ID/EX/MEM/WB) in-order core with no hazard interlock.
// Define BRANCH_FLUSH_EN to squash the three younger instructions on a taken branch.
module pipelined_cpu16
    import cpu16_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    output logic [7:0]  i_addr,
    output logic [7:0]  d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we
);

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] id_ir, ex_ir, mem_ir, wb_ir;
    logic [15:0] reg_A, reg_B, reg_C, reg_C1;
    logic [15:0] smdr, smdr1;
    logic [2:0]  flag;
    logic [15:0] gr [0:7];

    logic [4:0]  id_op, ex_op, mem_op, wb_op;
    logic [2:0]  id_r1, id_r2, id_r3, wb_rd;
    logic [15:0] reg_A_next, reg_B_next;
    logic [15:0] alu_result;
    logic        alu_cf, alu_zf, alu_nf;
    logic        branch_taken;
    logic        flush;
    logic        unused_bits;

    assign id_op  = id_ir[15:11];
    assign id_r1  = id_ir[10:8];
    assign id_r2  = id_ir[6:4];
    assign id_r3  = id_ir[2:0];
    assign ex_op  = ex_ir[15:11];
    assign mem_op = mem_ir[15:11];
    assign wb_op  = wb_ir[15:11];
    assign wb_rd  = wb_ir[10:8];

    assign unused_bits = ^{ex_ir[10:0], mem_ir[10:0], wb_ir[7:0]};

    assign i_addr    = pc;
    assign d_addr    = reg_C[7:0];
    assign d_dataout = smdr1;

    // Branches resolve in MEM against the flags as currently registered.
    always_comb begin
        case (mem_op)
            OP_JUMP, OP_JMPR: branch_taken = 1'b1;
            OP_BZ:            branch_taken = flag[ZF];
            OP_BNZ:           branch_taken = ~flag[ZF];
            OP_BN:            branch_taken = flag[NF];
            OP_BNN:           branch_taken = ~flag[NF];
            OP_BC:            branch_taken = flag[CF];
            OP_BNC:           branch_taken = ~flag[CF];
            default:          branch_taken = 1'b0;
        endcase
    end

`ifdef BRANCH_FLUSH_EN
    assign flush = branch_taken;
`else
    assign flush = 1'b0;
`endif

    // Operand selection for ID.
    always_comb begin
        reg_A_next = gr[id_r2];
        reg_B_next = gr[id_r3];
        if ((id_op == OP_LOAD) || (id_op == OP_STORE) || is_shift(id_op)) begin
            reg_A_next = gr[id_r2];
            reg_B_next = {12'b0, id_ir[3:0]};
        end else if ((id_op == OP_ADDI) || (id_op == OP_SUBI) ||
                     (id_op == OP_JMPR) || is_cond_branch(id_op)) begin
            reg_A_next = gr[id_r1];
            reg_B_next = {8'b0, id_ir[7:0]};
        end else if (id_op == OP_LDIH) begin
            reg_A_next = gr[id_r1];
            reg_B_next = {id_ir[7:0], 8'b0};
        end else if (id_op == OP_JUMP) begin
            reg_A_next = 16'h0000;
            reg_B_next = {8'b0, id_ir[7:0]};
        end
    end

    cpu16_alu u_alu (
        .op     (ex_op),
        .a      (reg_A),
        .b      (reg_B),
        .cf_in  (flag[CF]),
        .result (alu_result),
        .cf_out (alu_cf),
        .zf_out (alu_zf),
        .nf_out (alu_nf)
    );

    // Run state and IF stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= 8'h00;
            id_ir <= NOP_IR;
        end else if (enable) begin
            case (state)
                IDLE: if (start) state <= EXEC;
                EXEC: if (wb_op == OP_HALT) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (state == EXEC) begin
                id_ir <= flush ? NOP_IR : i_datain;
                pc    <= branch_taken ? reg_C[7:0] : pc + 8'd1;
            end
        end
    end

    // ID stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_ir <= NOP_IR;
            reg_A <= 16'h0000;
            reg_B <= 16'h0000;
            smdr  <= 16'h0000;
        end else if (enable) begin
            ex_ir <= flush ? NOP_IR : id_ir;
            reg_A <= reg_A_next;
            reg_B <= reg_B_next;
            smdr  <= gr[id_r1];
        end
    end

    // EX stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ir <= NOP_IR;
            reg_C  <= 16'h0000;
            smdr1  <= 16'h0000;
            d_we   <= 1'b0;
            flag   <= 3'b000;
        end else if (enable) begin
            mem_ir <= flush ? NOP_IR : ex_ir;
            reg_C  <= alu_result;
            smdr1  <= smdr;
            d_we   <= (ex_op == OP_STORE) && !flush;
            if (sets_flags(ex_op) && !flush) begin
                flag[CF] <= alu_cf;
                flag[ZF] <= alu_zf;
                flag[NF] <= alu_nf;
            end
        end
    end

    // MEM stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_C1 <= 16'h0000;
            wb_ir  <= NOP_IR;
        end else if (enable) begin
            reg_C1 <= (mem_op == OP_LOAD) ? d_datain : reg_C;
            wb_ir  <= mem_ir;
        end
    end

    // WB stage: one register per generate slice, written from reg_C1.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_gr
            logic [15:0] gr_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    gr_q <= 16'h0000;
                else if (enable && writes_reg(wb_op) && (wb_rd == 3'(gi)))
                    gr_q <= reg_C1;
            end
            assign gr[gi] = gr_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_cpu16.sv
// Directed bench for pipelined_cpu16: a table of ALU vectors run as tiny
// programs, plus hand-written branch, store, load, halt, freeze and reset sequences.
module tb_pipelined_cpu16;
    import cpu16_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [15:0] i_datain, d_datain, d_dataout;
    logic [7:0]  i_addr, d_addr;
    logic        d_we;

    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];

    always #5 clock = ~clock;

    pipelined_cpu16 dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we)
    );

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_r;
        logic [2:0]  exp_f;   // {nf, zf, cf}
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] enc_ri(input logic [4:0] op, input logic [2:0] r1,
                                           input logic [7:0] imm);
        return {op, r1, imm};
    endfunction

    function automatic logic [15:0] enc_rrr(input logic [4:0] op, input logic [2:0] rd,
                                            input logic [2:0] r2, input logic [2:0] r3);
        return {op, rd, 1'b0, r2, 1'b0, r3};
    endfunction

    function automatic logic [15:0] enc_rrv(input logic [4:0] op, input logic [2:0] rd,
                                            input logic [2:0] r2, input logic [3:0] v);
        return {op, rd, 1'b0, r2, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic adv_to(input int k);
        while (edge_n < k) begin
            step();
            edge_n++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = NOP_IR;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        step();
        step();
        reset  = 1'b1;
    endtask

    // After this, edge_n counts edges from the first fetch (edge 0 loads imem[0]).
    task automatic start_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        edge_n = -1;
    endtask

    task automatic build_alu_prog(input vec_t v);
        clear_mem();
        imem[0] = enc_ri(OP_LDIH, 3'd1, v.a[15:8]);
        imem[1] = enc_ri(OP_LDIH, 3'd2, v.b[15:8]);
        imem[4] = enc_ri(OP_ADDI, 3'd1, v.a[7:0]);
        imem[5] = enc_ri(OP_ADDI, 3'd2, v.b[7:0]);
        imem[6] = v.cin ? enc_ri(OP_SUBI, 3'd5, 8'h01) : enc_ri(OP_ADDI, 3'd5, 8'h00);
        if (is_shift(v.op))
            imem[9] = enc_rrv(v.op, 3'd3, 3'd1, v.b[3:0]);
        else
            imem[9] = enc_rrr(v.op, 3'd3, 3'd1, 3'd2);
        imem[13] = enc_ri(OP_HALT, 3'd0, 8'h00);
    endtask

    task automatic build_store_prog();
        clear_mem();
        imem[0] = enc_ri(OP_LDIH, 3'd2, 8'hAB);
        imem[1] = enc_ri(OP_ADDI, 3'd1, 8'h10);
        imem[4] = enc_ri(OP_ADDI, 3'd2, 8'hCD);
        imem[8] = enc_rrv(OP_STORE, 3'd2, 3'd1, 4'd3);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,  16'h0005, 16'h0003, 1'b0, 16'h0008, 3'b000};
        vecs[1]  = '{OP_ADD,  16'hFF80, 16'hFF80, 1'b0, 16'hFF00, 3'b101};
        vecs[2]  = '{OP_SUB,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 3'b101};
        vecs[3]  = '{OP_SUB,  16'h1234, 16'h1234, 1'b0, 16'h0000, 3'b010};
        vecs[4]  = '{OP_CMP,  16'h0005, 16'h0003, 1'b1, 16'h0000, 3'b000};
        vecs[5]  = '{OP_ADDC, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 3'b000};
        vecs[6]  = '{OP_SUBC, 16'h0010, 16'h0001, 1'b1, 16'h000E, 3'b000};
        vecs[7]  = '{OP_AND,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 3'b101};
        vecs[8]  = '{OP_OR,   16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 3'b000};
        vecs[9]  = '{OP_XOR,  16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 3'b011};
        vecs[10] = '{OP_SLL,  16'h8001, 16'h0001, 1'b1, 16'h0002, 3'b001};
        vecs[11] = '{OP_SRL,  16'h8000, 16'h0004, 1'b0, 16'h0800, 3'b000};
        vecs[12] = '{OP_SRA,  16'h8000, 16'h0004, 1'b0, 16'hF800, 3'b100};
        vecs[13] = '{OP_SLA,  16'h0003, 16'h000F, 1'b0, 16'h8000, 3'b100};

        // Reset state and idle hold.
        clear_mem();
        do_reset();
        chk("reset i_addr", 32'(i_addr), 32'h0);
        chk("reset d_we", 32'(d_we), 32'h0);
        chk("reset d_addr", 32'(d_addr), 32'h0);
        chk("reset d_dataout", 32'(d_dataout), 32'h0);
        chk("reset state", 32'(dut.state), 32'(IDLE));
        step();
        step();
        chk("idle pc hold", 32'(i_addr), 32'h0);

        // ALU table.
        for (int v = 0; v < 14; v++) begin
            build_alu_prog(vecs[v]);
            do_reset();
            start_prog();
            adv_to(20);
            chk($sformatf("vec%0d op%0h gr3", v, vecs[v].op), 32'(dut.gr[3]), 32'(vecs[v].exp_r));
            chk($sformatf("vec%0d op%0h flags", v, vecs[v].op), 32'(dut.flag), 32'(vecs[v].exp_f));
            chk($sformatf("vec%0d halted", v), 32'(dut.state), 32'(IDLE));
        end

        // BC not taken: gr1=0xff80 via ADDI leaves cf=0.
        clear_mem();
        imem[0] = enc_ri(OP_LDIH, 3'd1, 8'hFF);
        imem[4] = enc_ri(OP_ADDI, 3'd1, 8'h80);
        imem[8] = 16'hF182;
        do_reset();
        start_prog();
        adv_to(7);
        chk("bc_nt cf", 32'(dut.flag[CF]), 32'h0);
        adv_to(11);
        chk("bc_nt pc at mem", 32'(i_addr), 32'd12);
        adv_to(12);
        chk("bc_nt pc next", 32'(i_addr), 32'd13);

        // BC taken after ADD gr3,gr1,gr1 sets cf.
        clear_mem();
        imem[0]  = enc_ri(OP_LDIH, 3'd1, 8'hFF);
        imem[4]  = enc_ri(OP_ADDI, 3'd1, 8'h80);
        imem[8]  = enc_rrr(OP_ADD, 3'd3, 3'd1, 3'd1);
        imem[12] = 16'hF182;
        do_reset();
        start_prog();
        adv_to(12);
        chk("bc_t gr3", 32'(dut.gr[3]), 32'hFF00);
        chk("bc_t cf", 32'(dut.flag[CF]), 32'h1);
        adv_to(14);
        chk("bc_t pc before", 32'(i_addr), 32'd15);
        adv_to(15);
        chk("bc_t pc target", 32'(i_addr), 32'h02);
        adv_to(16);
        chk("bc_t pc after", 32'(i_addr), 32'h03);

        // STORE gr2,gr1,3 with enable freeze.
        build_store_prog();
        do_reset();
        start_prog();
        adv_to(9);
        chk("st d_we before", 32'(d_we), 32'h0);
        adv_to(10);
        chk("st d_we", 32'(d_we), 32'h1);
        chk("st d_addr", 32'(d_addr), 32'h13);
        chk("st d_dataout", 32'(d_dataout), 32'hABCD);
        enable = 1'b0;
        step();
        step();
        step();
        chk("frz d_we", 32'(d_we), 32'h1);
        chk("frz i_addr", 32'(i_addr), 32'd11);
        chk("frz d_addr", 32'(d_addr), 32'h13);
        enable = 1'b1;
        adv_to(11);
        chk("st d_we after", 32'(d_we), 32'h0);

        // Asynchronous reset in the middle of the store.
        build_store_prog();
        do_reset();
        start_prog();
        adv_to(10);
        chk("rst pre d_we", 32'(d_we), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst i_addr", 32'(i_addr), 32'h0);
        chk("rst d_we", 32'(d_we), 32'h0);
        chk("rst d_addr", 32'(d_addr), 32'h0);
        chk("rst d_dataout", 32'(d_dataout), 32'h0);
        reset = 1'b1;

        // LOAD gr4,gr1,2.
        clear_mem();
        dmem[8'h12] = 16'h1234;
        imem[0] = enc_ri(OP_ADDI, 3'd1, 8'h10);
        imem[4] = enc_rrv(OP_LOAD, 3'd4, 3'd1, 4'd2);
        do_reset();
        start_prog();
        adv_to(6);
        chk("ld d_addr", 32'(d_addr), 32'h12);
        chk("ld d_we", 32'(d_we), 32'h0);
        adv_to(7);
        chk("ld gr4 early", 32'(dut.gr[4]), 32'h0);
        adv_to(8);
        chk("ld gr4", 32'(dut.gr[4]), 32'h1234);

        // HALT: back to idle when HALT reaches WB, pc stops.
        clear_mem();
        imem[0] = enc_ri(OP_HALT, 3'd0, 8'h00);
        do_reset();
        start_prog();
        adv_to(3);
        chk("halt pc e3", 32'(i_addr), 32'd4);
        chk("halt state e3", 32'(dut.state), 32'(EXEC));
        adv_to(4);
        chk("halt state e4", 32'(dut.state), 32'(IDLE));
        adv_to(7);
        chk("halt pc stop", 32'(i_addr), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
